// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Oversamples uart_rxd with clk, samples
//               start/data/stop bits at mid-bit and outputs each byte with a
//               one-cycle valid strobe.
//               Optional macro UART_RX_BREAK_DETECT_EN enables BREAK detection.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  output logic       uart_rx_break,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CYC_W          = $clog2(CYCLES_PER_BIT) + 1;

  localparam logic [CYC_W-1:0] C_BIT_END  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [CYC_W-1:0] C_HALF_END = CYC_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [3:0]       C_LAST_BIT = 4'(PAYLOAD_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_sync_q, rxd_sync_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  // Set once a low stop bit was seen; the FSM then waits for the line to
  // return high so a held-low line does not look like a new start bit.
  logic             stop_seen_q, stop_seen_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic             brk_q, brk_d;
`endif

  logic w_bit_end;
  assign w_bit_end = (cyc_q == C_BIT_END);

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stop_seen_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      stop_seen_q <= stop_seen_d;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q       <= brk_d;
`endif
    end
  end

  // Next-state logic; dropping the enable aborts any frame in progress
  always_comb begin
    state_d = state_q;
    if (!uart_rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (!rxd_sync_q) state_d = ST_START;
        ST_START: if (cyc_q == C_HALF_END) state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        ST_DATA:  if (w_bit_end && (bit_q == C_LAST_BIT)) state_d = ST_STOP;
        ST_STOP: begin
          if (stop_seen_q) begin
            if (rxd_sync_q) state_d = ST_IDLE;
          end else if (w_bit_end && rxd_sync_q) begin
            state_d = ST_IDLE;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Synchronizer, bit timing, shift register and output pulses
  always_comb begin
    rxd_meta_d  = uart_rxd;
    rxd_sync_d  = rxd_meta_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    stop_seen_d = stop_seen_q;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d       = 1'b0;
`endif
    if (!uart_rx_en) begin
      cyc_d       = '0;
      bit_d       = '0;
      stop_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cyc_d       = '0;
          bit_d       = '0;
          stop_seen_d = 1'b0;
        end
        ST_START: begin
          cyc_d = (cyc_q == C_HALF_END) ? '0 : cyc_q + CYC_W'(1);
        end
        ST_DATA: begin
          if (w_bit_end) begin
            cyc_d                = '0;
            shift_d[bit_q[2:0]]  = rxd_sync_q;
            bit_d                = bit_q + 4'd1;
            if (bit_q == C_LAST_BIT) data_d = shift_d;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        ST_STOP: begin
          if (!stop_seen_q) begin
            if (w_bit_end) begin
              cyc_d = '0;
              if (rxd_sync_q) begin
                valid_d = 1'b1;
              end else begin
                stop_seen_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                if (data_q == 8'h00) brk_d = 1'b1;
`endif
              end
            end else begin
              cyc_d = cyc_q + CYC_W'(1);
            end
          end
        end
        default: cyc_d = '0;
      endcase
    end
  end

  assign uart_rx_valid = valid_q;
  assign uart_rx_data  = data_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign uart_rx_break = brk_q;
`else
  assign uart_rx_break = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (50 MHz, 115200 b/s).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int BIT_NS = 8680;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int brk_cnt = 0;

  uart_rx dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_break (uart_rx_break),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data)
  );

  always #10 clk = ~clk;

  // Pulse counters sampled on the falling edge, counting high cycles
  always @(negedge clk) begin
    if (uart_rx_valid) valid_cnt++;
    if (uart_rx_break) brk_cnt++;
  end

  // Start bit plus 8 data bits LSB first; leaves the line high (stop bit)
  task automatic drive_bits(input logic [7:0] b);
    uart_rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #BIT_NS;
    end
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset;
    resetn     = 1'b1;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (uart_rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 00", uart_rx_data); end
    n_cmp++; if (uart_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", uart_rx_valid); end
    n_cmp++; if (uart_rx_break !== 1'b0) begin n_err++; $display("FAIL reset_break: got %0b expected 0", uart_rx_break); end
    resetn    = 1'b0;
    valid_cnt = 0;
    brk_cnt   = 0;
    repeat (10000) @(posedge clk);
    #1;
    n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL idle_valid: got %0d pulses expected 0", valid_cnt); end
    n_cmp++; if (brk_cnt !== 0) begin n_err++; $display("FAIL idle_break: got %0d pulses expected 0", brk_cnt); end
  endtask

  task automatic test_bytes;
    logic [7:0] tbl [10];
    int v0;
    tbl = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'hC3, 8'h96, 8'h01};
    for (int k = 0; k < 10; k++) begin
      v0 = valid_cnt;
      drive_bits(tbl[k]);
      #1000;
      n_cmp++; if (uart_rx_data !== tbl[k]) begin n_err++; $display("FAIL byte%0d_data: got %0h expected %0h", k, uart_rx_data, tbl[k]); end
      // stop bit lasts 0.6 bit period before the next start edge
      #(BIT_NS * 6 / 10 - 1000);
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL byte%0d_valid: got %0d pulses expected 1", k, valid_cnt - v0); end
    end
    #BIT_NS;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    drive_bits(8'h55);
    #1000;
    n_cmp++; if (uart_rx_data !== 8'h55) begin n_err++; $display("FAIL b2b_first: got %0h expected 55", uart_rx_data); end
    #(BIT_NS - 1000);
    drive_bits(8'hAA);
    #1000;
    n_cmp++; if (uart_rx_data !== 8'hAA) begin n_err++; $display("FAIL b2b_second: got %0h expected aa", uart_rx_data); end
    #(BIT_NS - 1000);
    n_cmp++; if (valid_cnt - v0 !== 2) begin n_err++; $display("FAIL b2b_valid: got %0d pulses expected 2", valid_cnt - v0); end
  endtask

  task automatic test_glitch;
    int v0;
    int b0;
    v0 = valid_cnt;
    b0 = brk_cnt;
    uart_rxd = 1'b0;
    #2000;
    uart_rxd = 1'b1;
    #BIT_NS;
    n_cmp++; if (valid_cnt - v0 + brk_cnt - b0 !== 0) begin n_err++; $display("FAIL glitch_pulse: got %0d pulses expected 0", valid_cnt - v0 + brk_cnt - b0); end
    n_cmp++; if (uart_rx_data !== 8'hAA) begin n_err++; $display("FAIL glitch_data: got %0h expected aa", uart_rx_data); end
  endtask

  task automatic test_break;
    int v0;
    int b0;
    int exp_brk;
`ifdef UART_RX_BREAK_DETECT_EN
    exp_brk = 1;
`else
    exp_brk = 0;
`endif
    v0 = valid_cnt;
    b0 = brk_cnt;
    uart_rxd = 1'b0;
    #(12 * BIT_NS);
    uart_rxd = 1'b1;
    #BIT_NS;
    n_cmp++; if (brk_cnt - b0 !== exp_brk) begin n_err++; $display("FAIL break_pulse: got %0d pulses expected %0d", brk_cnt - b0, exp_brk); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL break_valid: got %0d pulses expected 0", valid_cnt - v0); end
    n_cmp++; if (uart_rx_data !== 8'h00) begin n_err++; $display("FAIL break_data: got %0h expected 00", uart_rx_data); end
    drive_bits(8'h3C);
    #1000;
    n_cmp++; if (uart_rx_data !== 8'h3C) begin n_err++; $display("FAIL after_break_data: got %0h expected 3c", uart_rx_data); end
    #(BIT_NS - 1000);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL after_break_valid: got %0d pulses expected 1", valid_cnt - v0); end
  endtask

  task automatic test_enable;
    logic [7:0] b;
    int v0;
    int b0;
    b  = 8'hF0;
    v0 = valid_cnt;
    b0 = brk_cnt;
    uart_rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      if (i == 3) begin
        #(BIT_NS / 2);
        uart_rx_en = 1'b0;
        #(BIT_NS / 2);
      end else begin
        #BIT_NS;
      end
    end
    uart_rxd = 1'b1;
    #BIT_NS;
    uart_rx_en = 1'b1;
    #BIT_NS;
    n_cmp++; if (uart_rx_data !== 8'h3C) begin n_err++; $display("FAIL disable_data: got %0h expected 3c", uart_rx_data); end
    n_cmp++; if (valid_cnt - v0 + brk_cnt - b0 !== 0) begin n_err++; $display("FAIL disable_pulse: got %0d pulses expected 0", valid_cnt - v0 + brk_cnt - b0); end
    drive_bits(8'h0F);
    #1000;
    n_cmp++; if (uart_rx_data !== 8'h0F) begin n_err++; $display("FAIL reenable_data: got %0h expected 0f", uart_rx_data); end
    #(BIT_NS - 1000);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL reenable_valid: got %0d pulses expected 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset;
    test_bytes;
    test_back_to_back;
    test_glitch;
    test_break;
    test_enable;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
